// File: rtl/my_mux_16_arb_pkg.sv
// rtl/my_mux_16_arb_pkg.sv - shared types and constants for the two-way 16-bit arbiter
package my_mux_16_arb_pkg;

  // Output register occupancy
  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  // Source encoding used for mux select, out_src and last_grant
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/my_mux_16.sv
// rtl/my_mux_16.sv - two-input 16-bit multiplexer
module my_mux_16 (
  output logic [15:0] out,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sel
);

  // sel = 0 passes a, sel = 1 passes b
  assign out = sel ? b : a;

endmodule

// File: rtl/my_mux_16_arbiter.sv
// rtl/my_mux_16_arbiter.sv - round-robin arbiter sharing one registered 16-bit channel between A and B
module my_mux_16_arbiter
  import my_mux_16_arb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [15:0]      a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [15:0]      b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [15:0]      out_data,
  input  logic             out_ready,
  output logic             out_src,
  output logic [CNT_W-1:0] grant_cnt_a,
  output logic [CNT_W-1:0] grant_cnt_b
);

  arb_state_e       state_q;
  logic [15:0]      out_data_q;
  logic             out_src_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;

  logic             space;
  logic             sel;
  logic             accept;
  logic [15:0]      mux_out;

  // Slot is free when empty or being drained; B wins when alone or when A was granted last
  always_comb begin
    space   = (state_q == ARB_EMPTY) || out_ready;
    sel     = b_valid && (!a_valid || (last_grant_q == SRC_A));
    a_ready = !reset && space && a_valid && !sel;
    b_ready = !reset && space && sel;
    accept  = a_ready || b_ready;
  end

  my_mux_16 u_mux (
    .out (mux_out),
    .a   (a_data),
    .b   (b_data),
    .sel (sel)
  );

  // Occupancy FSM with output register, grant history and saturating grant counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_EMPTY;
      out_data_q   <= 16'h0000;
      out_src_q    <= SRC_A;
      last_grant_q <= SRC_B;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
    end else begin
      if (accept) begin
        state_q      <= ARB_FULL;
        out_data_q   <= mux_out;
        out_src_q    <= sel;
        last_grant_q <= sel;
        if (sel == SRC_B) begin
          if (cnt_b_q != '1) cnt_b_q <= cnt_b_q + CNT_W'(1);
        end else begin
          if (cnt_a_q != '1) cnt_a_q <= cnt_a_q + CNT_W'(1);
        end
      end else if ((state_q == ARB_FULL) && out_ready) begin
        state_q <= ARB_EMPTY;
      end
    end
  end

  assign out_valid   = (state_q == ARB_FULL);
  assign out_data    = out_data_q;
  assign out_src     = out_src_q;
  assign grant_cnt_a = cnt_a_q;
  assign grant_cnt_b = cnt_b_q;

endmodule
